lime_rx_iq_deinterleaver: RTL and testbench

Receive-side front end for the Lime RF0 interface. It captures the interleaved 12-bit I/Q word stream on `rf_rxdata`, qualified by `rf_rxiqsel`, and pairs it into 24-bit complex samples. It tracks I/Q framing and can optionally remove DC offset. Output samples and a one-cycle strobe stay in the `rf0_rxclk` domain and feed the RX clock-crossing FIFO ahead of the DDC0 downconverter.

---
 rtl/lime_rx_iq_deinterleaver.sv | 190 +++++++++++++++++++
 tb/tb_lime_rx_iq_deinterleaver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lime_rx_iq_deinterleaver.sv
// Lime RF0 receive front end: pairs the interleaved 12-bit I/Q word stream into
// 24-bit complex samples, tracks framing lock and optionally removes DC offset.
module lime_rx_iq_deinterleaver #(
   parameter int unsigned DC_SHIFT  = 10,
   parameter int unsigned SYNC_LOCK = 4
) (
   input  logic        rf0_rxclk,
   input  logic        reset,
   input  logic        enable,
   input  logic        dc_en,
   input  logic        swap_iq,
   input  logic        rf_rxiqsel,
   input  logic [11:0] rf_rxdata,
   output logic [23:0] rx_iq,
   output logic        rx_strobe,
   output logic        sync_ok,
   output logic [7:0]  sync_err_count,
   output logic [15:0] sample_count
);

   localparam int unsigned DW = 12;
   localparam int unsigned AW = 13 + DC_SHIFT;
   localparam int unsigned GW = 4;
   localparam int unsigned EW = 8;
   localparam int unsigned CW = 16;
   localparam logic [GW-1:0] LOCK_CNT = GW'(SYNC_LOCK);

   typedef enum logic {
      HUNT   = 1'b0,
      HAVE_I = 1'b1
   } state_t;

   // x - (acc >>> DC_SHIFT), widened to 13 bits so it cannot overflow
   function automatic logic signed [DW:0] dc_diff(input logic [DW-1:0] x,
                                                  input logic signed [AW-1:0] acc);
      logic signed [DW-1:0] dc;
      dc = DW'(acc >>> DC_SHIFT);
      return $signed({x[DW-1], x}) - $signed({dc[DW-1], dc});
   endfunction

   function automatic logic [DW-1:0] sat_word(input logic signed [DW:0] d);
      if (d[DW] != d[DW-1]) begin
         return d[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
      return d[DW-1:0];
   endfunction

   // Saturating accumulate keeps the DC estimate from wrapping
   function automatic logic signed [AW-1:0] acc_add(input logic signed [AW-1:0] acc,
                                                    input logic signed [DW:0] d);
      logic signed [AW:0] sum;
      sum = $signed({acc[AW-1], acc}) + $signed({{(AW-DW){d[DW]}}, d});
      if (sum[AW] != sum[AW-1]) begin
         return sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
      end
      return sum[AW-1:0];
   endfunction

   state_t                state_q, state_d;
   logic                  in_vld_q, in_vld_d;
   logic                  in_is_i_q, in_is_i_d;
   logic [DW-1:0]         in_data_q, in_data_d;
   logic [DW-1:0]         i_hold_q, i_hold_d;
   logic signed [AW-1:0]  acc_i_q, acc_i_d;
   logic signed [AW-1:0]  acc_q_q, acc_q_d;
   logic [2*DW-1:0]       rx_iq_q, rx_iq_d;
   logic                  rx_strobe_q, rx_strobe_d;
   logic                  sync_ok_q, sync_ok_d;
   logic [GW-1:0]         good_q, good_d;
   logic [EW-1:0]         err_cnt_q, err_cnt_d;
   logic [CW-1:0]         smp_cnt_q, smp_cnt_d;

   logic signed [DW:0]    d_i_c, d_q_c;
   logic                  pair_c, ferr_c;

   assign d_i_c = dc_diff(i_hold_q, acc_i_q);
   assign d_q_c = dc_diff(in_data_q, acc_q_q);

   // Framing FSM, pair emission, lock tracking and DC removal
   always_comb begin
      state_d     = state_q;
      in_vld_d    = enable;
      in_is_i_d   = rf_rxiqsel ^ swap_iq;
      in_data_d   = rf_rxdata;
      i_hold_d    = i_hold_q;
      acc_i_d     = acc_i_q;
      acc_q_d     = acc_q_q;
      rx_iq_d     = rx_iq_q;
      rx_strobe_d = 1'b0;
      sync_ok_d   = sync_ok_q;
      good_d      = good_q;
      err_cnt_d   = err_cnt_q;
      smp_cnt_d   = smp_cnt_q;
      pair_c      = 1'b0;
      ferr_c      = 1'b0;

      if (!enable) begin
         state_d   = HUNT;
         sync_ok_d = 1'b0;
         good_d    = '0;
      end else if (in_vld_q) begin
         case (state_q)
            HUNT: begin
               if (in_is_i_q) begin
                  i_hold_d = in_data_q;
                  state_d  = HAVE_I;
               end else if (sync_ok_q) begin
                  ferr_c = 1'b1;
               end
            end
            HAVE_I: begin
               if (in_is_i_q) begin
                  i_hold_d = in_data_q;
                  ferr_c   = 1'b1;
               end else begin
                  pair_c  = 1'b1;
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end

      if (ferr_c) begin
         err_cnt_d = (err_cnt_q == {EW{1'b1}}) ? err_cnt_q : err_cnt_q + EW'(1);
         sync_ok_d = 1'b0;
         good_d    = '0;
      end

      if (pair_c) begin
         rx_strobe_d = 1'b1;
         smp_cnt_d   = smp_cnt_q + CW'(1);
         good_d      = (good_q == LOCK_CNT) ? good_q : good_q + GW'(1);
         if (good_d == LOCK_CNT) begin
            sync_ok_d = 1'b1;
         end
         if (dc_en) begin
            rx_iq_d = {sat_word(d_i_c), sat_word(d_q_c)};
            acc_i_d = acc_add(acc_i_q, d_i_c);
            acc_q_d = acc_add(acc_q_q, d_q_c);
         end else begin
            rx_iq_d = {i_hold_q, in_data_q};
         end
      end

      if (!dc_en) begin
         acc_i_d = '0;
         acc_q_d = '0;
      end
   end

   always_ff @(posedge rf0_rxclk) begin
      if (reset) begin
         state_q     <= HUNT;
         in_vld_q    <= 1'b0;
         in_is_i_q   <= 1'b0;
         in_data_q   <= '0;
         i_hold_q    <= '0;
         acc_i_q     <= '0;
         acc_q_q     <= '0;
         rx_iq_q     <= '0;
         rx_strobe_q <= 1'b0;
         sync_ok_q   <= 1'b0;
         good_q      <= '0;
         err_cnt_q   <= '0;
         smp_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         in_vld_q    <= in_vld_d;
         in_is_i_q   <= in_is_i_d;
         in_data_q   <= in_data_d;
         i_hold_q    <= i_hold_d;
         acc_i_q     <= acc_i_d;
         acc_q_q     <= acc_q_d;
         rx_iq_q     <= rx_iq_d;
         rx_strobe_q <= rx_strobe_d;
         sync_ok_q   <= sync_ok_d;
         good_q      <= good_d;
         err_cnt_q   <= err_cnt_d;
         smp_cnt_q   <= smp_cnt_d;
      end
   end

   assign rx_iq          = rx_iq_q;
   assign rx_strobe      = rx_strobe_q;
   assign sync_ok        = sync_ok_q;
   assign sync_err_count = err_cnt_q;
   assign sample_count   = smp_cnt_q;

endmodule

// File: tb/tb_lime_rx_iq_deinterleaver.sv
// Directed bench for lime_rx_iq_deinterleaver: word-level reference model checked
// every cycle, plus hand-computed literal expectations for the key scenarios.
module tb_lime_rx_iq_deinterleaver;

   localparam int DCS = 4;
   localparam int SL  = 4;

   logic        clk = 1'b0;
   logic        reset, enable, dc_en, swap_iq, rf_rxiqsel;
   logic [11:0] rf_rxdata;
   logic [23:0] rx_iq;
   logic        rx_strobe, sync_ok;
   logic [7:0]  sync_err_count;
   logic [15:0] sample_count;

   always #5 clk = ~clk;

   lime_rx_iq_deinterleaver #(.DC_SHIFT(DCS), .SYNC_LOCK(SL)) dut (
      .rf0_rxclk      (clk),
      .reset          (reset),
      .enable         (enable),
      .dc_en          (dc_en),
      .swap_iq        (swap_iq),
      .rf_rxiqsel     (rf_rxiqsel),
      .rf_rxdata      (rf_rxdata),
      .rx_iq          (rx_iq),
      .rx_strobe      (rx_strobe),
      .sync_ok        (sync_ok),
      .sync_err_count (sync_err_count),
      .sample_count   (sample_count)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Scenario mode
   bit g_en = 0, g_dce = 0, g_sw = 0;

   // Reference model: expected visible outputs after the latest edge
   bit          m_have_i = 0, m_sync = 0, m_stb = 0;
   int          m_hold = 0, m_acc_i = 0, m_acc_q = 0, m_good = 0, m_err = 0, m_cnt = 0;
   logic [23:0] m_iq = '0;
   // Word presented at the previous edge
   bit          p_rst = 1, p_en = 0, p_sel = 0, p_sw = 0;
   logic [11:0] p_data = '0;

   function automatic int sx12(input logic [11:0] v);
      return v[11] ? int'(v) - 4096 : int'(v);
   endfunction

   task automatic dc_chan(input int x, inout int acc, output logic [11:0] y);
      int d;
      d = x - (acc >>> DCS);
      if (d > 2047)       y = 12'h7FF;
      else if (d < -2048) y = 12'h800;
      else                y = 12'(d);
      acc = acc + d;
   endtask

   task automatic frame_err();
      if (m_err < 255) m_err++;
      m_sync = 0;
      m_good = 0;
   endtask

   task automatic emit_pair(input int i, input int q);
      logic [11:0] yi, yq;
      if (dc_en) begin
         dc_chan(i, m_acc_i, yi);
         dc_chan(q, m_acc_q, yq);
      end else begin
         yi = 12'(i);
         yq = 12'(q);
      end
      m_iq  = {yi, yq};
      m_stb = 1;
      m_cnt = (m_cnt + 1) % 65536;
      if (m_good < SL) m_good++;
      if (m_good == SL) m_sync = 1;
   endtask

   // A word sampled at one edge takes effect at the next; reset/enable act immediately
   task automatic model_edge();
      m_stb = 0;
      if (reset) begin
         m_have_i = 0; m_sync = 0; m_hold = 0; m_acc_i = 0; m_acc_q = 0;
         m_good = 0; m_err = 0; m_cnt = 0; m_iq = '0;
      end else begin
         if (!enable) begin
            m_have_i = 0;
            m_sync   = 0;
            m_good   = 0;
         end else if (p_en && !p_rst) begin
            if (p_sel ^ p_sw) begin
               if (m_have_i) frame_err();
               m_hold   = sx12(p_data);
               m_have_i = 1;
            end else if (m_have_i) begin
               emit_pair(m_hold, sx12(p_data));
               m_have_i = 0;
            end else if (m_sync) begin
               frame_err();
            end
         end
         if (!dc_en) begin
            m_acc_i = 0;
            m_acc_q = 0;
         end
      end
   endtask

   task automatic compare();
      logic [49:0] act, exp;
      act = {rx_iq, rx_strobe, sync_ok, sync_err_count, sample_count};
      exp = {m_iq, m_stb, m_sync, 8'(m_err), 16'(m_cnt)};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL cycle %0d: got iq=%h stb=%b sync=%b err=%0d cnt=%0d, expected iq=%h stb=%b sync=%b err=%0d cnt=%0d",
                  cyc, rx_iq, rx_strobe, sync_ok, sync_err_count, sample_count,
                  m_iq, m_stb, m_sync, m_err, m_cnt);
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int all_zero();
      return (rx_iq == 24'h0 && !rx_strobe && !sync_ok &&
              sync_err_count == 8'h0 && sample_count == 16'h0) ? 1 : 0;
   endfunction

   // Drive one word, advance one clock, update the model and check at the falling edge
   task automatic step(input bit r, input bit sel, input logic [11:0] dat);
      reset      = r;
      enable     = g_en;
      dc_en      = g_dce;
      swap_iq    = g_sw;
      rf_rxiqsel = sel;
      rf_rxdata  = dat;
      @(posedge clk);
      cyc++;
      model_edge();
      p_rst = r; p_en = g_en; p_sel = sel; p_sw = g_sw; p_data = dat;
      @(negedge clk);
      compare();
   endtask

   initial begin
      int prev_i, cur_i, viol;

      step(1, 0, 12'h000);
      step(1, 0, 12'h000);
      chk("reset_state", all_zero(), 1);

      // Plain alternating stream
      g_en = 1;
      for (int p = 0; p < 100; p++) begin
         step(0, 1, 12'h17F);
         if (p == 1) begin
            chk("first_pair_iq", int'(rx_iq), 'h17FF81);
            chk("first_pair_strobe", int'(rx_strobe), 1);
         end
         if (p == 3) chk("sync_before_4th", int'(sync_ok), 0);
         if (p == 4) chk("sync_at_4th", int'(sync_ok), 1);
         step(0, 0, 12'hF81);
         if (p == 1) chk("strobe_gap", int'(rx_strobe), 0);
      end
      step(0, 1, 12'h001);
      chk("count_100", int'(sample_count), 100);
      chk("err_clean", int'(sync_err_count), 0);
      chk("iq_100", int'(rx_iq), 'h17FF81);

      // Double-I framing error while locked
      step(0, 1, 12'h002);
      step(0, 0, 12'h003);
      chk("double_i_err", int'(sync_err_count), 1);
      chk("double_i_unlock", int'(sync_ok), 0);
      step(0, 1, 12'h17F);
      chk("pair_after_err", int'(rx_iq), 'h002003);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 12'hF81);
         step(0, 1, 12'h17F);
         if (k == 1) chk("relock_3rd", int'(sync_ok), 0);
         if (k == 2) chk("relock_4th", int'(sync_ok), 1);
      end
      step(0, 0, 12'hF81);
      step(0, 1, 12'h17F);

      // Swapped qualifier
      g_en = 0;
      step(0, 0, 12'h000);
      g_en = 1; g_sw = 1;
      step(0, 1, 12'h17F);
      step(0, 0, 12'hF81);
      step(0, 1, 12'h17F);
      step(0, 0, 12'hF81);
      chk("swap_pair", int'(rx_iq), 'hF8117F);

      // DC removal on a constant input
      g_sw = 0; g_dce = 1;
      step(1, 0, 12'h000);
      prev_i = 4096;
      viol   = 0;
      for (int p = 0; p < 200; p++) begin
         step(0, 1, 12'h100);
         if (p == 1) chk("dc_first_out", int'(rx_iq), 'h100100);
         if (p >= 1) begin
            cur_i = sx12(rx_iq[23:12]);
            if (cur_i > prev_i || cur_i < 0) viol++;
            prev_i = cur_i;
         end
         step(0, 0, 12'h100);
      end
      for (int p = 0; p < 40; p++) begin
         step(0, 1, 12'h800);
         if (p == 0) begin
            cur_i = sx12(rx_iq[23:12]);
            chk("dc_settled", (cur_i >= -1 && cur_i <= 1) ? 1 : 0, 1);
         end
         step(0, 0, 12'h800);
      end
      chk("dc_monotonic", viol, 0);
      step(0, 1, 12'h7FF);
      step(0, 0, 12'h800);
      step(0, 1, 12'h7FF);
      chk("sat_pos", int'(rx_iq[23:12]), 'h7FF);

      // Reset while holding an I word
      g_dce = 0;
      step(1, 0, 12'h456);
      chk("reset_mid_pair", all_zero(), 1);
      step(0, 0, 12'h456);
      chk("reset_no_strobe", all_zero(), 1);
      step(0, 1, 12'h0AA);
      chk("no_orphan_pair", all_zero(), 1);

      // Enable dropped while holding I, re-raised on a Q word
      g_en = 0;
      step(0, 0, 12'h055);
      g_en = 1;
      step(0, 0, 12'h066);
      step(0, 1, 12'h011);
      chk("en_drop_no_strobe", int'(rx_strobe), 0);
      chk("en_drop_no_err", int'(sync_err_count), 0);
      step(0, 0, 12'h022);
      step(0, 1, 12'h033);
      chk("resume_pair", int'(rx_iq), 'h011022);
      chk("resume_count", int'(sample_count), 1);
      step(0, 0, 12'h044);

      // Repeated double-Q errors after relocking
      for (int e = 0; e < 300; e++) begin
         for (int k = 0; k < 5; k++) begin
            step(0, 1, 12'h010);
            step(0, 0, 12'h020);
         end
         step(0, 0, 12'h030);
      end
      step(0, 1, 12'h010);
      chk("err_saturated", int'(sync_err_count), 255);
      chk("sat_err_unlock", int'(sync_ok), 0);
      step(0, 0, 12'h020);
      step(0, 1, 12'h010);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
